fp_wb_ctrl: RTL and testbench

// - Writeback/retire stage directly downstream of the FPU wrapper. Tracks issued FP ops in order,

---
 rtl/fp_wb_pkg.sv | 18 +
 rtl/fp_wb_fifo.sv | 63 ++++++
 rtl/fp_wb_ctrl.sv | 134 +++++++++++++
 tb/tb_fp_wb_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_wb_pkg.sv
// Shared types and constants for the FP writeback/retire stage.
// Tracked-op entries, flag widths and fflags bit positions.
package fp_wb_pkg;

   localparam int FFLAGS_W = 5;

   localparam int FF_NV = 4;
   localparam int FF_DZ = 3;
   localparam int FF_OF = 2;
   localparam int FF_UF = 1;
   localparam int FF_NX = 0;

   typedef struct packed {
      logic [4:0] rd;
      logic       is_int;
   } wb_entry_t;

endpackage

// File: rtl/fp_wb_fifo.sv
// In-order FIFO of in-flight FP op destinations.
// Flush empties it in one cycle; caller guards push/pop against full/empty.
module fp_wb_fifo
   import fp_wb_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          flush_i,
   input  logic          push_i,
   input  wb_entry_t     push_data_i,
   input  logic          pop_i,
   output wb_entry_t     head_o,
   output logic          full_o,
   output logic [CW-1:0] count_o
);

   wb_entry_t       mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;

endmodule

// File: rtl/fp_wb_ctrl.sv
// FP writeback/retire stage: pairs FPU results with in-order destinations,
// drives the registered RF write port, sticky fflags and RAW/WAW scoreboard.
module fp_wb_ctrl
   import fp_wb_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int NUM_REGS = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   input  logic                issue_valid_i,
   output logic                issue_ready_o,
   input  logic [4:0]          issue_rd_i,
   input  logic                issue_int_i,
   input  logic                fpu_valid_i,
   input  logic [31:0]         fpu_result_i,
   input  logic [FFLAGS_W-1:0] fpu_status_i,
   input  logic [2:0][4:0]     query_rs_i,
   input  logic [2:0]          query_int_i,
   output logic                hazard_o,
   output logic                fp_we_o,
   output logic                int_we_o,
   output logic [4:0]          wb_addr_o,
   output logic [31:0]         wb_data_o,
   output logic [FFLAGS_W-1:0] fflags_o,
   input  logic                fflags_clr_i,
   output logic                orphan_o
);

   localparam int CW = $clog2(DEPTH) + 1;

   wb_entry_t     head;
   wb_entry_t     push_data;
   logic          full, empty, push, pop;
   logic [CW-1:0] count;

   logic [NUM_REGS-1:0] pend_fp_q, pend_fp_d;
   logic [NUM_REGS-1:0] pend_int_q, pend_int_d;
   logic                fp_we_q, fp_we_d;
   logic                int_we_q, int_we_d;
   logic                orphan_q, orphan_d;
   logic [4:0]          wb_addr_q, wb_addr_d;
   logic [31:0]         wb_data_q, wb_data_d;
   logic [FFLAGS_W-1:0] fflags_q, fflags_d;

   assign empty     = (count == '0);
   assign push_data = '{rd: issue_rd_i, is_int: issue_int_i};

   // WAW stall: a second writer to a pending reg waits for the first
   assign issue_ready_o = !full && !flush_i &&
      !(issue_int_i ? pend_int_q[issue_rd_i] : pend_fp_q[issue_rd_i]);

   assign push = issue_valid_i && issue_ready_o;
   assign pop  = fpu_valid_i && !empty && !flush_i;

   fp_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (pop),
      .head_o      (head),
      .full_o      (full),
      .count_o     (count)
   );

   always_comb begin
      pend_fp_d  = pend_fp_q;
      pend_int_d = pend_int_q;
      if (pop) begin
         if (head.is_int) pend_int_d[head.rd] = 1'b0;
         else             pend_fp_d[head.rd]  = 1'b0;
      end
      if (push) begin
         if (issue_int_i) pend_int_d[issue_rd_i] = 1'b1;
         else             pend_fp_d[issue_rd_i]  = 1'b1;
      end
      pend_int_d[0] = 1'b0;
      if (flush_i) begin
         pend_fp_d  = '0;
         pend_int_d = '0;
      end
   end

   always_comb begin
      hazard_o = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (query_int_i[i]) hazard_o |= pend_int_q[query_rs_i[i]];
         else                hazard_o |= pend_fp_q[query_rs_i[i]];
      end
   end

   always_comb begin
      fp_we_d   = pop && !head.is_int;
      int_we_d  = pop && head.is_int && (head.rd != 5'd0);
      orphan_d  = fpu_valid_i && empty && !flush_i;
      wb_addr_d = pop ? head.rd : wb_addr_q;
      wb_data_d = pop ? fpu_result_i : wb_data_q;
      fflags_d  = fflags_clr_i ? '0 : fflags_q;
      if (pop) fflags_d = fflags_d | fpu_status_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_fp_q  <= '0;
         pend_int_q <= '0;
         fp_we_q    <= 1'b0;
         int_we_q   <= 1'b0;
         orphan_q   <= 1'b0;
         wb_addr_q  <= '0;
         wb_data_q  <= '0;
         fflags_q   <= '0;
      end else begin
         pend_fp_q  <= pend_fp_d;
         pend_int_q <= pend_int_d;
         fp_we_q    <= fp_we_d;
         int_we_q   <= int_we_d;
         orphan_q   <= orphan_d;
         wb_addr_q  <= wb_addr_d;
         wb_data_q  <= wb_data_d;
         fflags_q   <= fflags_d;
      end
   end

   assign fp_we_o   = fp_we_q;
   assign int_we_o  = int_we_q;
   assign orphan_o  = orphan_q;
   assign wb_addr_o = wb_addr_q;
   assign wb_data_o = wb_data_q;
   assign fflags_o  = fflags_q;

endmodule

// File: tb/tb_fp_wb_ctrl.sv
// Directed bench for fp_wb_ctrl: issue/retire ordering, scoreboard,
// fflags accumulation, flush, orphan results and async reset.
module tb_fp_wb_ctrl;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            flush_i;
   logic            issue_valid_i;
   logic            issue_ready_o;
   logic [4:0]      issue_rd_i;
   logic            issue_int_i;
   logic            fpu_valid_i;
   logic [31:0]     fpu_result_i;
   logic [4:0]      fpu_status_i;
   logic [2:0][4:0] query_rs_i;
   logic [2:0]      query_int_i;
   logic            hazard_o;
   logic            fp_we_o;
   logic            int_we_o;
   logic [4:0]      wb_addr_o;
   logic [31:0]     wb_data_o;
   logic [4:0]      fflags_o;
   logic            fflags_clr_i;
   logic            orphan_o;

   int tests = 0;
   int fails = 0;

   fp_wb_ctrl dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .flush_i       (flush_i),
      .issue_valid_i (issue_valid_i),
      .issue_ready_o (issue_ready_o),
      .issue_rd_i    (issue_rd_i),
      .issue_int_i   (issue_int_i),
      .fpu_valid_i   (fpu_valid_i),
      .fpu_result_i  (fpu_result_i),
      .fpu_status_i  (fpu_status_i),
      .query_rs_i    (query_rs_i),
      .query_int_i   (query_int_i),
      .hazard_o      (hazard_o),
      .fp_we_o       (fp_we_o),
      .int_we_o      (int_we_o),
      .wb_addr_o     (wb_addr_o),
      .wb_data_o     (wb_data_o),
      .fflags_o      (fflags_o),
      .fflags_clr_i  (fflags_clr_i),
      .orphan_o      (orphan_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   task automatic q_fp(input logic [4:0] rs);
      query_rs_i  = '0;
      query_int_i = 3'b111;
      query_rs_i[0]  = rs;
      query_int_i[0] = 1'b0;
      #1;
   endtask

   task automatic issue(input logic [4:0] rd, input logic is_int);
      issue_valid_i = 1'b1;
      issue_rd_i    = rd;
      issue_int_i   = is_int;
   endtask

   task automatic retire(input logic [31:0] res, input logic [4:0] st);
      fpu_valid_i  = 1'b1;
      fpu_result_i = res;
      fpu_status_i = st;
   endtask

   task automatic idle();
      issue_valid_i = 1'b0;
      fpu_valid_i   = 1'b0;
      fpu_status_i  = '0;
      flush_i       = 1'b0;
      fflags_clr_i  = 1'b0;
   endtask

   initial begin
      rst_ni       = 1'b0;
      issue_rd_i   = '0;
      issue_int_i  = 1'b0;
      fpu_result_i = '0;
      query_rs_i   = '0;
      query_int_i  = 3'b111;
      idle();
      #3;
      check("rst_ready", 32'(issue_ready_o), 32'd1);
      check("rst_fp_we", 32'(fp_we_o), 32'd0);
      check("rst_data", wb_data_o, 32'd0);
      check("rst_fflags", 32'(fflags_o), 32'd0);
      #4 rst_ni = 1'b1;
      tick();

      // single FP op, RAW hazard until write
      issue(5'd3, 1'b0);
      #1 check("s1_ready", 32'(issue_ready_o), 32'd1);
      tick();
      idle();
      q_fp(5'd3);
      check("s1_haz_pend", 32'(hazard_o), 32'd1);
      tick();
      retire(32'h3F80_0000, 5'd0);
      #1 check("s1_haz_retire", 32'(hazard_o), 32'd1);
      tick();
      idle();
      #1;
      check("s1_fp_we", 32'(fp_we_o), 32'd1);
      check("s1_int_we", 32'(int_we_o), 32'd0);
      check("s1_addr", 32'(wb_addr_o), 32'd3);
      check("s1_data", wb_data_o, 32'h3F80_0000);
      check("s1_haz_clear", 32'(hazard_o), 32'd0);
      tick();
      check("s1_we_pulse", 32'(fp_we_o), 32'd0);
      check("s1_data_hold", wb_data_o, 32'h3F80_0000);

      // fill FIFO, then drain in order
      issue(5'd1, 1'b0); tick();
      issue(5'd2, 1'b0); tick();
      issue(5'd4, 1'b0); tick();
      issue(5'd5, 1'b0); tick();
      issue(5'd6, 1'b0);
      query_rs_i = '0; query_int_i = 3'b011; query_rs_i[2] = 5'd4;
      #1;
      check("s2_full_ready", 32'(issue_ready_o), 32'd0);
      check("s2_haz_rs3", 32'(hazard_o), 32'd1);
      issue_valid_i = 1'b0;
      retire(32'hA1, 5'd0);
      tick();
      #1;
      check("s2_ready_after", 32'(issue_ready_o), 32'd1);
      check("s2_addr1", 32'(wb_addr_o), 32'd1);
      check("s2_data1", wb_data_o, 32'hA1);
      retire(32'hA2, 5'd0); tick();
      check("s2_addr2", 32'(wb_addr_o), 32'd2);
      retire(32'hA4, 5'd0); tick();
      check("s2_addr4", 32'(wb_addr_o), 32'd4);
      retire(32'hA5, 5'd0); tick();
      idle();
      check("s2_addr5", 32'(wb_addr_o), 32'd5);
      check("s2_data5", wb_data_o, 32'hA5);
      check("s2_we5", 32'(fp_we_o), 32'd1);
      tick();

      // integer destinations and sticky flags
      issue(5'd7, 1'b1);
      tick();
      query_rs_i = '0; query_int_i = 3'b111; query_rs_i[0] = 5'd7;
      #1 check("s3_haz_int", 32'(hazard_o), 32'd1);
      issue(5'd8, 1'b1);
      retire(32'h1, 5'b10000);
      tick();
      idle();
      retire(32'h0, 5'b00001);
      #1;
      check("s3_int_we", 32'(int_we_o), 32'd1);
      check("s3_fp_we", 32'(fp_we_o), 32'd0);
      check("s3_addr7", 32'(wb_addr_o), 32'd7);
      check("s3_data7", wb_data_o, 32'd1);
      check("s3_ff_nv", 32'(fflags_o), 32'h10);
      tick();
      idle();
      check("s3_addr8", 32'(wb_addr_o), 32'd8);
      check("s3_ff_sticky", 32'(fflags_o), 32'h11);
      fflags_clr_i = 1'b1;
      tick();
      idle();
      check("s3_ff_clr", 32'(fflags_o), 32'd0);

      // clear-then-OR in one cycle, and int x0 never written
      issue(5'd0, 1'b1);
      tick();
      idle();
      query_rs_i = '0; query_int_i = 3'b111;
      #1 check("s3_x0_haz", 32'(hazard_o), 32'd0);
      retire(32'h5, 5'b00100);
      fflags_clr_i = 1'b1;
      tick();
      idle();
      check("s3_x0_we", 32'(int_we_o), 32'd0);
      check("s3_clr_or", 32'(fflags_o), 32'h04);
      fflags_clr_i = 1'b1;
      tick();
      idle();

      // WAW stall on rd 9
      issue(5'd9, 1'b0);
      tick();
      #1 check("s4_waw0", 32'(issue_ready_o), 32'd0);
      tick();
      check("s4_waw1", 32'(issue_ready_o), 32'd0);
      retire(32'h99, 5'd0);
      #1 check("s4_waw_retire", 32'(issue_ready_o), 32'd0);
      tick();
      fpu_valid_i = 1'b0;
      #1 check("s4_ready", 32'(issue_ready_o), 32'd1);
      tick();
      idle();
      retire(32'h9A, 5'd0);
      tick();
      idle();
      check("s4_addr9", 32'(wb_addr_o), 32'd9);
      check("s4_data9", wb_data_o, 32'h9A);

      // flush with a retire in the same cycle
      issue(5'd10, 1'b0); tick();
      issue(5'd11, 1'b0); tick();
      issue(5'd12, 1'b0); tick();
      issue(5'd13, 1'b0);
      flush_i = 1'b1;
      retire(32'hDEAD, 5'b11111);
      #1 check("s5_ready_flush", 32'(issue_ready_o), 32'd0);
      tick();
      idle();
      issue_rd_i = 5'd13;
      q_fp(5'd10);
      check("s5_no_we", 32'(fp_we_o), 32'd0);
      check("s5_no_ff", 32'(fflags_o), 32'd0);
      check("s5_orph0", 32'(orphan_o), 32'd0);
      check("s5_haz10", 32'(hazard_o), 32'd0);
      q_fp(5'd12);
      check("s5_haz12", 32'(hazard_o), 32'd0);
      q_fp(5'd13);
      check("s5_haz13", 32'(hazard_o), 32'd0);
      check("s5_ready", 32'(issue_ready_o), 32'd1);
      retire(32'hBEEF, 5'b00010);
      tick();
      idle();
      check("s5_orphan", 32'(orphan_o), 32'd1);
      check("s5_orph_we", 32'(fp_we_o), 32'd0);
      check("s5_orph_ff", 32'(fflags_o), 32'd0);
      tick();
      check("s5_orph_pulse", 32'(orphan_o), 32'd0);

      // async reset with ops in flight
      issue(5'd14, 1'b0); tick();
      issue(5'd15, 1'b0); tick();
      issue(5'd16, 1'b0);
      retire(32'h1234, 5'b00100);
      tick();
      idle();
      q_fp(5'd15);
      check("s6_haz15", 32'(hazard_o), 32'd1);
      check("s6_ff", 32'(fflags_o), 32'h04);
      check("s6_data", wb_data_o, 32'h1234);
      rst_ni = 1'b0;
      #1;
      check("s6_rst_haz15", 32'(hazard_o), 32'd0);
      check("s6_rst_fp_we", 32'(fp_we_o), 32'd0);
      check("s6_rst_addr", 32'(wb_addr_o), 32'd0);
      check("s6_rst_data", wb_data_o, 32'd0);
      check("s6_rst_ff", 32'(fflags_o), 32'd0);
      q_fp(5'd16);
      check("s6_rst_haz16", 32'(hazard_o), 32'd0);
      issue_rd_i = 5'd16;
      #1 check("s6_rst_ready", 32'(issue_ready_o), 32'd1);
      #3 rst_ni = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
